// File: rtl/alu_seq_pkg.sv
// Shared definitions for the programmable ALU sequencer: opcode constants,
// FSM state type, program memory geometry and a length clamp helper.
package alu_seq_pkg;

   localparam int PROG_DEPTH = 8;
   localparam int INSTR_W    = 7;

   localparam logic [2:0] OP_INC   = 3'b000;
   localparam logic [2:0] OP_RADD  = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_LOGIC = 3'b011;
   localparam logic [2:0] OP_NZ    = 3'b100;
   localparam logic [2:0] OP_SHL   = 3'b101;
   localparam logic [2:0] OP_SHR   = 3'b110;
   localparam logic [2:0] OP_MUL   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Lengths above the program depth run the whole program once.
   function automatic logic [3:0] clamp_len(input logic [3:0] len_in);
      return (len_in > 4'd8) ? 4'd8 : len_in;
   endfunction

endpackage

// File: rtl/alu_prog_seq_if.sv
// Program-load / run-control bus of the ALU sequencer. The master side
// (host or bench) drives programming and start; the slave side is the core.
interface alu_prog_seq_if;
   import alu_seq_pkg::*;

   logic               prog_we;
   logic [2:0]         prog_addr;
   logic [INSTR_W-1:0] prog_data;
   logic [3:0]         prog_len;
   logic               start;
   logic               busy;
   logic               done;
   logic [2:0]         pc;
   logic [7:0]         acc;

   modport master (
      output prog_we, prog_addr, prog_data, prog_len, start,
      input  busy, done, pc, acc
   );

   modport slave (
      input  prog_we, prog_addr, prog_data, prog_len, start,
      output busy, done, pc, acc
   );

endinterface

// File: rtl/alu_core.sv
// Combinational datapath: one instruction (op, a) applied to b = acc[3:0],
// producing a zero-extended 8-bit result.
module alu_core
   import alu_seq_pkg::*;
(
   input  logic [2:0] op,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] res
);

   logic [4:0] ripple_sum;
   logic [4:0] carry;
   logic [7:0] shl_res;
   logic [7:0] shr_res;

   // Explicit bit-serial carry chain so OP_RADD is built from full adders.
   always_comb begin
      carry      = '0;
      ripple_sum = '0;
      for (int i = 0; i < 4; i++) begin
         ripple_sum[i] = a[i] ^ b[i] ^ carry[i];
         carry[i+1]    = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      ripple_sum[4] = carry[4];
   end

   // Shift amounts of 8 or more (a[3] set) push every bit out.
   always_comb begin
      shl_res = '0;
      shr_res = '0;
      if (!a[3]) begin
         shl_res = {4'b0, b} << a[2:0];
         shr_res = {4'b0, b} >> a[2:0];
      end
   end

   // Opcode select.
   always_comb begin
      res = '0;
      case (op)
         OP_INC:   res = {3'b0, {1'b0, a} + 5'd1};
         OP_RADD:  res = {3'b0, ripple_sum};
         OP_ADD:   res = {3'b0, {1'b0, a} + {1'b0, b}};
         OP_LOGIC: res = {a | b, a ^ b};
         OP_NZ:    res = ({a, b} != 8'h00) ? 8'h01 : 8'h00;
         OP_SHL:   res = shl_res;
         OP_SHR:   res = shr_res;
         OP_MUL:   res = {4'b0, a} * {4'b0, b};
         default:  res = '0;
      endcase
   end

endmodule

// File: rtl/alu_prog_seq.sv
// Programmable ALU sequencer: an 8-slot program memory executed one
// instruction per cycle into an 8-bit accumulator.
// Optional build macro ALU_SEQ_STEP_EN adds a 'step' port that gates
// each RUN cycle; without it RUN advances every cycle.
module alu_prog_seq
   import alu_seq_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
`ifdef ALU_SEQ_STEP_EN
   input  logic step,
`endif
   alu_prog_seq_if.slave bus
);

   state_t             state;
   state_t             next_state;
   logic [7:0]         acc;
   logic [2:0]         pc;
   logic [3:0]         len;
   logic [INSTR_W-1:0] prog_mem [PROG_DEPTH];
   logic [INSTR_W-1:0] run_prog [PROG_DEPTH];
   logic [INSTR_W-1:0] cur_instr;
   logic [7:0]         alu_res;
   logic [3:0]         eff_len;
   logic               advance;
   logic               last_instr;
   logic               start_ok;
   logic               busy;
   logic               done;

`ifdef ALU_SEQ_STEP_EN
   assign advance = step;
`else
   assign advance = 1'b1;
`endif

   assign eff_len    = clamp_len(bus.prog_len);
   assign start_ok   = bus.start && (state != ST_RUN);
   assign last_instr = ({1'b0, pc} == (len - 4'd1));
   assign cur_instr  = run_prog[pc];

   alu_core u_alu_core (
      .op  (cur_instr[6:4]),
      .a   (cur_instr[3:0]),
      .b   (acc[3:0]),
      .res (alu_res)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   // Next-state and status outputs.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) next_state = (eff_len == 4'd0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (advance && last_instr) next_state = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
            if (bus.start) next_state = (eff_len == 4'd0) ? ST_DONE : ST_RUN;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Accumulator, program counter and latched length. pc parks on the last
   // instruction so a full 8-slot program never wraps.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc <= '0;
         pc  <= '0;
         len <= '0;
      end else if (start_ok) begin
         acc <= '0;
         pc  <= '0;
         len <= eff_len;
      end else if (state == ST_RUN && advance) begin
         acc <= alu_res;
         if (!last_instr) pc <= pc + 3'd1;
      end
   end

   // Program memory plus a snapshot taken at start, so a write landing on
   // the same edge as start only affects later runs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < PROG_DEPTH; i++) begin
            prog_mem[i] <= '0;
            run_prog[i] <= '0;
         end
      end else begin
         if (start_ok) begin
            for (int i = 0; i < PROG_DEPTH; i++) run_prog[i] <= prog_mem[i];
         end
         if (bus.prog_we && state != ST_RUN) prog_mem[bus.prog_addr] <= bus.prog_data;
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.pc   = pc;
   assign bus.acc  = acc;

endmodule

// File: tb/tb_alu_prog_seq.sv
// Self-checking bench for alu_prog_seq: directed programs plus randomized
// programs compared against an arithmetic reference model.
// Honours ALU_SEQ_STEP_EN when defined.
module tb_alu_prog_seq;

   logic clk;
   logic reset_n;
   logic step;
   int   total;
   int   bad;

   logic [6:0] model_mem [8];
   logic [7:0] last_acc;

   alu_prog_seq_if bus ();

   alu_prog_seq dut (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef ALU_SEQ_STEP_EN
      .step    (step),
`endif
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int unsigned act, input int unsigned req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, req);
      end
   endtask

   // Reference ALU computed with plain integer arithmetic.
   function automatic logic [7:0] aluModel(input logic [6:0] ins, input logic [7:0] accv);
      int op, a, b, r;
      op = int'(ins[6:4]);
      a  = int'(ins[3:0]);
      b  = int'(accv[3:0]);
      case (op)
         0:       r = a + 1;
         1, 2:    r = a + b;
         3:       r = (a | b) * 16 + (a ^ b);
         4:       r = (a != 0 || b != 0) ? 1 : 0;
         5:       r = (a >= 8) ? 0 : (b * (2 ** a)) % 256;
         6:       r = (a >= 8) ? 0 : b / (2 ** a);
         default: r = a * b;
      endcase
      return r[7:0];
   endfunction

   task automatic doWrite(input logic [2:0] addr, input logic [6:0] data);
      bus.prog_we   = 1'b1;
      bus.prog_addr = addr;
      bus.prog_data = data;
      tick();
      bus.prog_we   = 1'b0;
      model_mem[addr] = data;
   endtask

   // Start a run and follow it cycle by cycle against the model.
   task automatic applyStimulus(input logic [3:0] len_in, input bit inject,
                                input bit sew, input logic [6:0] sew_data);
      int         eff;
      int         k;
      int         cycles;
      bit         step_v;
      logic [7:0] exp_acc;
      logic [6:0] snap [8];
      eff = (len_in > 4'd8) ? 8 : int'(len_in);
      for (int i = 0; i < 8; i++) snap[i] = model_mem[i];
      bus.start    = 1'b1;
      bus.prog_len = len_in;
      if (sew) begin
         bus.prog_we   = 1'b1;
         bus.prog_addr = 3'd0;
         bus.prog_data = sew_data;
         model_mem[0]  = sew_data;
      end
      tick();
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      exp_acc = 8'h00;
      k       = 0;
      cycles  = 0;
      while (k < eff && cycles < 100) begin
         checkOutput("busy_run", bus.busy, 1);
         checkOutput("done_run", bus.done, 0);
         checkOutput("pc_run", bus.pc, k);
         checkOutput("acc_run", bus.acc, exp_acc);
         step_v = 1'b1;
`ifdef ALU_SEQ_STEP_EN
         if (cycles >= 1 && cycles <= 5) step_v = 1'b0;
         else step_v = ($urandom_range(0, 3) != 0);
`endif
         step = step_v;
         if (inject && cycles == 0) begin
            bus.start     = 1'b1;
            bus.prog_len  = 4'($urandom);
            bus.prog_we   = 1'b1;
            bus.prog_addr = 3'd0;
            bus.prog_data = 7'($urandom);
         end
         tick();
         cycles++;
         bus.start   = 1'b0;
         bus.prog_we = 1'b0;
         step        = 1'b1;
         if (step_v) begin
            exp_acc = aluModel(snap[k], exp_acc);
            k++;
         end
      end
      if (k < eff) checkOutput("run_timeout", k, eff);
      checkOutput("done_end", bus.done, 1);
      checkOutput("busy_end", bus.busy, 0);
      checkOutput("acc_end", bus.acc, exp_acc);
      last_acc = exp_acc;
   endtask

   // DONE must hold acc and done while start stays low.
   task automatic checkHold(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         checkOutput("done_hold", bus.done, 1);
         checkOutput("acc_hold", bus.acc, last_acc);
      end
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      step          = 1'b1;
      reset_n       = 1'b0;
      bus.prog_we   = 1'b0;
      bus.prog_addr = 3'd0;
      bus.prog_data = 7'd0;
      bus.prog_len  = 4'd0;
      bus.start     = 1'b0;
      for (int i = 0; i < 8; i++) model_mem[i] = 7'd0;

      // Reset state
      tick();
      tick();
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_done", bus.done, 0);
      checkOutput("rst_pc", bus.pc, 0);
      checkOutput("rst_acc", bus.acc, 0);
      reset_n = 1'b1;
      tick();

      // Single increment
      doWrite(3'd0, {3'b000, 4'd3});
      applyStimulus(4'd1, 1'b0, 1'b0, 7'd0);
      checkOutput("inc_final", bus.acc, 8'h04);
      checkHold(3);

      // Inc, multiply, shift-left
      doWrite(3'd0, {3'b000, 4'd2});
      doWrite(3'd1, {3'b111, 4'd5});
      doWrite(3'd2, {3'b101, 4'd4});
      applyStimulus(4'd3, 1'b0, 1'b0, 7'd0);
      checkOutput("mulshl_final", bus.acc, 8'hF0);

      // Inc then or/xor pack
      doWrite(3'd0, {3'b000, 4'd4});
      doWrite(3'd1, {3'b011, 4'd5});
      applyStimulus(4'd2, 1'b0, 1'b0, 7'd0);
      checkOutput("logic_final", bus.acc, 8'h50);

      // Zero length goes straight to DONE
      applyStimulus(4'd0, 1'b0, 1'b0, 7'd0);
      checkOutput("len0_acc", bus.acc, 8'h00);

      // Writes and start during RUN are ignored
      doWrite(3'd0, {3'b000, 4'd2});
      doWrite(3'd1, {3'b111, 4'd5});
      doWrite(3'd2, {3'b101, 4'd4});
      applyStimulus(4'd3, 1'b1, 1'b0, 7'd0);
      checkOutput("inject_final", bus.acc, 8'hF0);

      // Write and start on the same edge: run sees old slot 0
      applyStimulus(4'd3, 1'b0, 1'b1, {3'b000, 4'd9});
      checkOutput("sew_final", bus.acc, 8'hF0);
      applyStimulus(4'd1, 1'b0, 1'b0, 7'd0);
      checkOutput("sew_next", bus.acc, 8'h0A);

      // Reset in the middle of a run clears everything
      bus.start    = 1'b1;
      bus.prog_len = 4'd3;
      tick();
      bus.start = 1'b0;
      tick();
      checkOutput("mid_pc", bus.pc, 1);
      reset_n = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checkOutput("mid_rst_busy", bus.busy, 0);
      checkOutput("mid_rst_done", bus.done, 0);
      checkOutput("mid_rst_acc", bus.acc, 0);
      checkOutput("mid_rst_pc", bus.pc, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) model_mem[i] = 7'd0;
      tick();
      applyStimulus(4'd1, 1'b0, 1'b0, 7'd0);
      checkOutput("rst_slot0", bus.acc, 8'h01);

      // Oversized length runs all eight slots
      for (int i = 0; i < 8; i++) doWrite(3'(i), 7'($urandom));
      applyStimulus(4'd12, 1'b0, 1'b0, 7'd0);

      // Randomized programs
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) doWrite(3'(i), 7'($urandom));
         end
         applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 7'($urandom));
         checkHold(int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
